fetch_pc_gen: RTL and testbench
===============================

FETCH_PC_GEN -- requirements
Module: fetch_pc_gen

Interface
REQ-001 Parameter ADDR_W, default 32, PC and target width.
REQ-002 Parameter FETCH_W, default 2 (legal 1/2/4), instructions per fetch group; group size G = 4*FETCH_W bytes.
REQ-003 Parameter RESET_VEC, default 32'h0000_0000, first fetch address after reset.
REQ-004 Parameter STALL_W, default 6, pipeline stall vector width.
REQ-005 clk  in  1  sole clock, all state updates on rising edge.
REQ-006 rst  in  1  synchronous, active-low reset (0 = reset at clock edge).
REQ-007 stall  in  STALL_W  pipeline stall vector; bit 0 = fetch stage stalled.
REQ-008 flush_i  in  1  exception/flush redirect request.
REQ-009 flush_target_i  in  ADDR_W  flush redirect address.
REQ-010 branch_flag_i  in  1  branch taken.
REQ-011 branch_target_address_i  in  ADDR_W  branch target.
REQ-012 imem_ready_i  in  1  instruction memory accepts the current fetch.
REQ-013 pc  out  ADDR_W  current fetch address.
REQ-014 ce  out  1  instruction memory chip enable.
REQ-015 slot_valid_o  out  FETCH_W  valid instruction slots in current group.
REQ-016 redirect_pending_o  out  1  a buffered redirect awaits application.
REQ-017 misalign_o  out  1  one-cycle pulse: applied target had nonzero bits [1:0].

Function
REQ-018 States OFF (ce=0), RUN, PEND (redirect buffered); advance = (stall[0]==NoStop) & imem_ready_i & ce.
REQ-019 OFF -> RUN unconditionally on the first edge with rst high; ce=1 and pc=RESET_VEC in that cycle.
REQ-020 RUN, advance, no redirect: pc <= (pc & ~(G-1)) + G, modulo 2^ADDR_W (wrap to 0, no flag).
REQ-021 flush_i high in RUN or PEND: pc <= flush_target_i at next edge regardless of stall and imem_ready_i; pending cleared; state RUN.
REQ-022 Priority: flush_i over branch_flag_i over buffered redirect over sequential increment.
REQ-023 RUN, branch_flag_i, advance: pc <= branch target next edge (one-cycle redirect latency).
REQ-024 RUN, branch_flag_i, no advance: target latched, pc held, state PEND, redirect_pending_o=1 next cycle.
REQ-025 PEND, advance: pc <= latched target, state RUN, redirect_pending_o=0.
REQ-026 PEND, new branch_flag_i: latched target overwritten (latest wins); applied when advance holds that cycle.
REQ-027 No advance and no redirect: pc, slot_valid_o, state hold.
REQ-028 Any applied target has bits [1:0] forced to 0; misalign_o=1 for exactly the cycle that pc is presented.
REQ-029 slot_valid_o[i] = ce & (i >= pc[log2(G)-1:2]); all slots valid when pc group-aligned.

Reset
REQ-030 rst low at an edge: ce=0, pc=RESET_VEC, state OFF, pending target cleared, redirect_pending_o=0, misalign_o=0, slot_valid_o=0.
REQ-031 Reset mid-PEND or mid-flush discards the redirect; fetch restarts at RESET_VEC.
REQ-032 Reset takes priority over every input on the same edge.

Structure
REQ-033 Shared defines file holds RstEnable (1'b0), ChipEnable/ChipDisable, Stop/NoStop, Branch, InstAddrBus, and OFF/RUN/PEND encodings.
REQ-034 One sub-module pc_redirect_arb: combinational priority select, [1:0] forcing, misalign detect; state and registers stay in fetch_pc_gen.

Verification (FETCH_W=2, RESET_VEC=32'hBFC0_0000 unless noted)
REQ-035 rst=0 for 3 cycles then 1 -> ce=0 during reset; next cycle ce=1, pc=BFC00000, slot_valid_o=2'b11; following cycle pc=BFC00008.
REQ-036 RUN, branch to 0x104 -> pc=0x104, slot_valid_o=2'b10; next pc=0x108, slot_valid_o=2'b11.
REQ-037 branch to 0x200 with stall[0]=1 for 2 cycles -> pc held, redirect_pending_o=1; first edge after release pc=0x200, pending=0.
REQ-038 flush to 0x380 with simultaneous branch to 0x200, stall[0]=1, imem_ready_i=0 -> pc=0x380 next edge, pending=0.
REQ-039 branch to 0x203 -> pc=0x200, misalign_o high exactly one cycle; pc=FFFFFFF8 advancing -> pc=0x0.
REQ-040 rst=0 while in PEND with target 0x500 -> pc=BFC00000 after release; 0x500 never fetched.

Source files
------------

// File: rtl/fetch_pc_gen_pkg.sv
// Shared constants and state encoding for the fetch PC generator.
// Holds the reset/enable/stall polarities and the fetch FSM encoding.
package fetch_pc_gen_pkg;

  localparam logic RstEnable   = 1'b0;
  localparam logic ChipEnable  = 1'b1;
  localparam logic ChipDisable = 1'b0;
  localparam logic Stop        = 1'b1;
  localparam logic NoStop      = 1'b0;
  localparam logic Branch      = 1'b1;
  localparam int   InstAddrBus = 32;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_pc_gen_if.sv
// Instruction-memory fetch port: fetch address, chip enable, slot mask and ready.
// Handshake: the fetch of pc is accepted at a rising edge when ce & imem_ready_i are both high
// (and the fetch stage is not stalled); pc and slot_valid_o are stable until then.
interface fetch_pc_gen_if #(
  parameter int ADDR_W  = 32,
  parameter int FETCH_W = 2
);
  logic [ADDR_W-1:0]  pc;
  logic               ce;
  logic [FETCH_W-1:0] slot_valid_o;
  logic               imem_ready_i;

  modport master (output pc, output ce, output slot_valid_o, input imem_ready_i);
  modport slave  (input pc, input ce, input slot_valid_o, output imem_ready_i);
endinterface

// File: rtl/fetch_pc_gen_pc_redirect_arb.sv
// Combinational next-PC select: flush > branch > buffered redirect > sequential.
// Applied targets are word-aligned and a misalignment flag is raised for them.
module pc_redirect_arb #(
  parameter int ADDR_W  = 32,
  parameter int FETCH_W = 2
) (
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] flush_target_i,
  input  logic              branch_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  input  logic              pend_valid_i,
  input  logic [ADDR_W-1:0] pend_target_i,
  input  logic              advance_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic [ADDR_W-1:0] next_pc_o,
  output logic              misalign_o
);
  localparam int GroupBytes = 4 * FETCH_W;

  logic [ADDR_W-1:0] raw_target;
  logic              load;

  always_comb begin
    raw_target = '0;
    load       = 1'b0;
    if (flush_i) begin
      raw_target = flush_target_i;
      load       = 1'b1;
    end else if (branch_i) begin
      raw_target = branch_target_i;
      load       = advance_i;
    end else if (pend_valid_i) begin
      raw_target = pend_target_i;
      load       = advance_i;
    end

    if (load) begin
      next_pc_o = {raw_target[ADDR_W-1:2], 2'b00};
    end else if (advance_i) begin
      next_pc_o = (pc_i & ~ADDR_W'(GroupBytes - 1)) + ADDR_W'(GroupBytes);
    end else begin
      next_pc_o = pc_i;
    end
    misalign_o = load & (raw_target[1:0] != 2'b00);
  end
endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch PC generator: sequential group fetch with flush/branch redirects,
// buffering a branch that arrives while fetch cannot advance.
module fetch_pc_gen
  import fetch_pc_gen_pkg::*;
#(
  parameter int              ADDR_W    = InstAddrBus,
  parameter int              FETCH_W   = 2,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter int              STALL_W   = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [STALL_W-1:0]  stall,
  input  logic                flush_i,
  input  logic [ADDR_W-1:0]   flush_target_i,
  input  logic                branch_flag_i,
  input  logic [ADDR_W-1:0]   branch_target_address_i,
  fetch_pc_gen_if.master      imem,
  output logic                redirect_pending_o,
  output logic                misalign_o,
  output fetch_state_e        state_o
);
  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pend_target_q, pend_target_d;
  logic              misalign_q, misalign_d;

  logic              ce;
  logic              advance;
  logic              branch_taken;
  logic [ADDR_W-1:0] arb_next_pc;
  logic              arb_misalign;
  logic              stall_unused;

  assign stall_unused = ^stall[STALL_W-1:0];
  assign branch_taken = (branch_flag_i == Branch);
  assign advance      = (stall[0] == NoStop) & imem.imem_ready_i & ce;

  pc_redirect_arb #(.ADDR_W(ADDR_W), .FETCH_W(FETCH_W)) u_arb (
    .flush_i         (flush_i),
    .flush_target_i  (flush_target_i),
    .branch_i        (branch_taken),
    .branch_target_i (branch_target_address_i),
    .pend_valid_i    (state_q == PEND),
    .pend_target_i   (pend_target_q),
    .advance_i       (advance),
    .pc_i            (pc_q),
    .next_pc_o       (arb_next_pc),
    .misalign_o      (arb_misalign)
  );

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q       <= OFF;
      pc_q          <= RESET_VEC;
      pend_target_q <= '0;
      misalign_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_target_q <= pend_target_d;
      misalign_q    <= misalign_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_target_d = pend_target_q;
    misalign_d    = 1'b0;
    case (state_q)
      OFF: state_d = RUN;
      RUN, PEND: begin
        pc_d       = arb_next_pc;
        misalign_d = arb_misalign;
        if (flush_i) begin
          state_d       = RUN;
          pend_target_d = '0;
        end else if (branch_taken && !advance) begin
          // Latest branch wins; it waits here until fetch can advance.
          state_d       = PEND;
          pend_target_d = branch_target_address_i;
        end else if (advance) begin
          state_d       = RUN;
          pend_target_d = '0;
        end
      end
      default: state_d = OFF;
    endcase
  end

  always_comb begin
    logic [ADDR_W-1:0] grp_off;
    ce                 = (state_q == OFF) ? ChipDisable : ChipEnable;
    redirect_pending_o = (state_q == PEND);
    misalign_o         = misalign_q;
    state_o            = state_q;
    grp_off            = (pc_q >> 2) & ADDR_W'(FETCH_W - 1);
    imem.pc            = pc_q;
    imem.ce            = ce;
    imem.slot_valid_o  = '0;
    for (int i = 0; i < FETCH_W; i++) begin
      imem.slot_valid_o[i] = ce & (ADDR_W'(i) >= grp_off);
    end
  end
endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed bench for fetch_pc_gen with FETCH_W=2, RESET_VEC=BFC00000.
module tb_fetch_pc_gen;
  import fetch_pc_gen_pkg::*;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        flush_i;
  logic [31:0] flush_target_i;
  logic        branch_flag_i;
  logic [31:0] branch_target_address_i;
  logic        redirect_pending_o;
  logic        misalign_o;
  fetch_state_e state_o;

  int checks;
  int errors;

  fetch_pc_gen_if #(.ADDR_W(32), .FETCH_W(2)) imem_if ();

  fetch_pc_gen #(
    .ADDR_W(32), .FETCH_W(2), .RESET_VEC(32'hBFC0_0000), .STALL_W(6)
  ) dut (
    .clk                     (clk),
    .rst                     (rst),
    .stall                   (stall),
    .flush_i                 (flush_i),
    .flush_target_i          (flush_target_i),
    .branch_flag_i           (branch_flag_i),
    .branch_target_address_i (branch_target_address_i),
    .imem                    (imem_if.master),
    .redirect_pending_o      (redirect_pending_o),
    .misalign_o              (misalign_o),
    .state_o                 (state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic branch(input logic [31:0] tgt);
    branch_flag_i           = 1'b1;
    branch_target_address_i = tgt;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    stall = '0;
    flush_i = 1'b0;
    flush_target_i = '0;
    branch_flag_i = 1'b0;
    branch_target_address_i = '0;
    imem_if.imem_ready_i = 1'b1;

    // Reset held three edges, with a flush present to show reset priority
    flush_i = 1'b1; flush_target_i = 32'h0000_0700;
    repeat (3) tick();
    check("rst_ce", imem_if.ce, 0);
    check("rst_pc", imem_if.pc, 32'hBFC0_0000);
    check("rst_slot", imem_if.slot_valid_o, 0);
    check("rst_pend", redirect_pending_o, 0);
    check("rst_mis", misalign_o, 0);
    flush_i = 1'b0;
    rst = 1'b1;
    tick();
    check("boot_ce", imem_if.ce, 1);
    check("boot_pc", imem_if.pc, 32'hBFC0_0000);
    check("boot_slot", imem_if.slot_valid_o, 2'b11);
    tick();
    check("seq_pc", imem_if.pc, 32'hBFC0_0008);

    // Memory not ready: pc holds
    imem_if.imem_ready_i = 1'b0;
    tick();
    check("hold_pc", imem_if.pc, 32'hBFC0_0008);
    imem_if.imem_ready_i = 1'b1;

    // Branch into middle of a group
    branch(32'h104);
    tick();
    branch_flag_i = 1'b0;
    check("br_pc", imem_if.pc, 32'h104);
    check("br_slot", imem_if.slot_valid_o, 2'b10);
    tick();
    check("br_seq_pc", imem_if.pc, 32'h108);
    check("br_seq_slot", imem_if.slot_valid_o, 2'b11);

    // Branch under a 2-cycle stall is buffered
    stall = 6'b000001;
    branch(32'h200);
    tick();
    branch_flag_i = 1'b0;
    check("pend1_pc", imem_if.pc, 32'h108);
    check("pend1_flag", redirect_pending_o, 1);
    tick();
    check("pend2_pc", imem_if.pc, 32'h108);
    check("pend2_flag", redirect_pending_o, 1);
    stall = '0;
    tick();
    check("pend_apply_pc", imem_if.pc, 32'h200);
    check("pend_apply_flag", redirect_pending_o, 0);

    // Flush beats a simultaneous branch and a buffered one, ignoring stall/ready
    stall = 6'b000001;
    branch(32'h600);
    tick();
    check("pre_flush_pend", redirect_pending_o, 1);
    imem_if.imem_ready_i = 1'b0;
    flush_i = 1'b1; flush_target_i = 32'h380;
    branch(32'h200);
    tick();
    flush_i = 1'b0; branch_flag_i = 1'b0;
    stall = '0; imem_if.imem_ready_i = 1'b1;
    check("flush_pc", imem_if.pc, 32'h380);
    check("flush_pend", redirect_pending_o, 0);
    tick();
    check("flush_seq_pc", imem_if.pc, 32'h388);

    // Misaligned target: forced aligned, one-cycle flag
    branch(32'h203);
    tick();
    branch_flag_i = 1'b0;
    check("mis_pc", imem_if.pc, 32'h200);
    check("mis_flag", misalign_o, 1);
    tick();
    check("mis_next_pc", imem_if.pc, 32'h208);
    check("mis_clear", misalign_o, 0);

    // Latest buffered branch wins
    stall = 6'b000001;
    branch(32'h300);
    tick();
    branch(32'h400);
    tick();
    branch_flag_i = 1'b0;
    check("latest_hold", imem_if.pc, 32'h208);
    stall = '0;
    tick();
    check("latest_pc", imem_if.pc, 32'h400);

    // Address wrap
    branch(32'hFFFF_FFF8);
    tick();
    branch_flag_i = 1'b0;
    check("wrap_pre", imem_if.pc, 32'hFFFF_FFF8);
    tick();
    check("wrap_pc", imem_if.pc, 32'h0);
    check("wrap_mis", misalign_o, 0);

    // Reset in PEND discards the buffered target
    stall = 6'b000001;
    branch(32'h500);
    tick();
    branch_flag_i = 1'b0;
    check("rp_pend", redirect_pending_o, 1);
    stall = '0;
    rst = 1'b0;
    tick();
    check("rp_ce", imem_if.ce, 0);
    check("rp_pend_clr", redirect_pending_o, 0);
    rst = 1'b1;
    tick();
    check("rp_boot_pc", imem_if.pc, 32'hBFC0_0000);
    tick();
    check("rp_seq_pc", imem_if.pc, 32'hBFC0_0008);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
